// File: rtl/div_8bit.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes, one quotient bit
// per cycle, followed by sign fix-up. Fixed latency from the Start edge to Done, any operands.
module div_8bit #(
    parameter int unsigned BITWIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [BITWIDTH-1:0] i_dividend,
    input  logic [BITWIDTH-1:0] i_divisor,
    output logic                o_busy,
    output logic                o_done,
    output logic [BITWIDTH-1:0] o_quot,
    output logic [BITWIDTH-1:0] o_rem,
    output logic                o_of,
    output logic                o_dz
);

    localparam int unsigned CW = $clog2(BITWIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [BITWIDTH-1:0] r_dvd;       // dividend magnitude, shifted out as quotient shifts in
    logic [BITWIDTH-1:0] r_dsr;       // divisor magnitude
    logic [BITWIDTH-1:0] r_prem;      // partial remainder; always below |divisor|
    logic [BITWIDTH-1:0] r_dividend;  // raw dividend, returned as remainder on divide-by-zero
    logic [CW-1:0]       r_cnt;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_ovf;
    logic                r_dsr_zero;
    logic [BITWIDTH-1:0] r_quot;
    logic [BITWIDTH-1:0] r_rem;
    logic                r_of;
    logic                r_dz;

    logic                w_accept;
    logic [BITWIDTH:0]   w_shift;
    logic [BITWIDTH:0]   w_trial;
    logic                w_qbit;
    logic [BITWIDTH-1:0] w_dvd_mag;
    logic [BITWIDTH-1:0] w_dsr_mag;
    logic [BITWIDTH-1:0] w_min_val;

    assign w_min_val = {1'b1, {(BITWIDTH-1){1'b0}}};
    assign w_accept  = (r_state == StIdle) && i_start;
    assign w_dvd_mag = i_dividend[BITWIDTH-1] ? -i_dividend : i_dividend;
    assign w_dsr_mag = i_divisor[BITWIDTH-1] ? -i_divisor : i_divisor;

    // 9-bit trial subtract; its sign bit decides keep-or-restore.
    assign w_shift = {r_prem, r_dvd[BITWIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dsr};
    assign w_qbit  = ~w_trial[BITWIDTH];

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (i_start) w_state_next = StCalc;
            StCalc: if (r_cnt == CW'(BITWIDTH - 1)) w_state_next = StFix;
            StFix:  w_state_next = StDone;
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_dvd      <= '0;
            r_dsr      <= '0;
            r_prem     <= '0;
            r_dividend <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_ovf      <= 1'b0;
            r_dsr_zero <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_of       <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_dvd      <= w_dvd_mag;
                r_dsr      <= w_dsr_mag;
                r_prem     <= '0;
                r_dividend <= i_dividend;
                r_cnt      <= '0;
                r_neg_q    <= i_dividend[BITWIDTH-1] ^ i_divisor[BITWIDTH-1];
                r_neg_r    <= i_dividend[BITWIDTH-1];
                r_ovf      <= (i_dividend == w_min_val) && (i_divisor == '1);
                r_dsr_zero <= (i_divisor == '0);
            end else if (r_state == StCalc) begin
                r_prem <= w_qbit ? w_trial[BITWIDTH-1:0] : w_shift[BITWIDTH-1:0];
                r_dvd  <= {r_dvd[BITWIDTH-2:0], w_qbit};
                r_cnt  <= r_cnt + 1'b1;
            end else if (r_state == StFix) begin
                if (r_dsr_zero) begin
                    r_quot <= '0;
                    r_rem  <= r_dividend;
                    r_of   <= 1'b0;
                    r_dz   <= 1'b1;
                end else if (r_ovf) begin
                    r_quot <= w_min_val;
                    r_rem  <= '0;
                    r_of   <= 1'b1;
                    r_dz   <= 1'b0;
                end else begin
                    r_quot <= r_neg_q ? -r_dvd : r_dvd;
                    r_rem  <= r_neg_r ? -r_prem : r_prem;
                    r_of   <= 1'b0;
                    r_dz   <= 1'b0;
                end
            end
        end
    end

    assign o_busy = (r_state == StCalc) || (r_state == StFix);
    assign o_done = (r_state == StDone);
    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_of   = r_of;
    assign o_dz   = r_dz;

endmodule

// File: tb/tb_div_8bit.sv
// Directed bench for div_8bit: expected results are queued at each accepted Start and
// popped when Done is seen; latency, Busy span, hold, abort and back-to-back pacing checked.
module tb_div_8bit;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       of;
        logic       dz;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, of, dz;
    logic [7:0] quot, rem;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] last_q = '0;
    logic [7:0] last_r = '0;

    div_8bit #(.BITWIDTH(8)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_start   (start),
        .i_dividend(dividend),
        .i_divisor (divisor),
        .o_busy    (busy),
        .o_done    (done),
        .o_quot    (quot),
        .o_rem     (rem),
        .o_of      (of),
        .o_dz      (dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb observed=done expected=no_result_pending", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_quot"}, quot, e.q);
            chk({tag, "_rem"}, rem, e.r);
            chk({tag, "_of"}, of, e.of);
            chk({tag, "_dz"}, dz, e.dz);
            last_q = e.q;
            last_r = e.r;
        end
    endtask

    // Drives one operation; optionally pulses Start with other operands mid-CALC.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic eof, input logic edz, input bit glitch);
        int   n;
        logic seen;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back('{q: eq, r: er, of: eof, dz: edz});
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        chk({tag, "_busy0"}, busy, 1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (glitch && n == 3) begin
                start = 1'b1; dividend = 8'd1; divisor = 8'd1;
            end else if (glitch && n == 4) begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
            else if (n <= 8) begin
                chk({tag, "_busy"}, busy, 1);
                chk({tag, "_hold_q"}, quot, last_q);
                chk({tag, "_hold_r"}, rem, last_r);
            end
        end
        chk({tag, "_latency"}, n, 9);
        if (seen) begin
            chk({tag, "_busy_at_done"}, busy, 0);
            pop_compare(tag);
        end
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int   n;
        int   t_first;
        int   ndone;
        logic abort_seen;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quot, 8'h00);
        chk("rst_rem", rem, 8'h00);
        chk("rst_of", of, 0);
        chk("rst_dz", dz, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op("p100_7", 8'd100, 8'd7, 8'h0E, 8'h02, 0, 0, 0);
        run_op("n100_7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 0, 0, 0);
        run_op("p100_n7", 8'd100, 8'hF9, 8'hF2, 8'h02, 0, 0, 0);
        run_op("n100_n7", 8'h9C, 8'hF9, 8'h0E, 8'hFE, 0, 0, 0);
        run_op("min_n1", 8'h80, 8'hFF, 8'h80, 8'h00, 1, 0, 0);
        run_op("min_1", 8'h80, 8'h01, 8'h80, 8'h00, 0, 0, 0);
        run_op("max_min", 8'h7F, 8'h80, 8'h00, 8'h7F, 0, 0, 0);
        run_op("dz5", 8'd5, 8'd0, 8'h00, 8'h05, 0, 1, 0);
        run_op("p9_3", 8'd9, 8'd3, 8'h03, 8'h00, 0, 0, 0);
        run_op("glitch", 8'd100, 8'd7, 8'h0E, 8'h02, 0, 0, 1);

        // Start held high: two operations, Done pulses 11 cycles apart.
        @(negedge clk);
        dividend = 8'd9;
        divisor  = 8'd3;
        start    = 1'b1;
        sb.push_back('{q: 8'h03, r: 8'h00, of: 1'b0, dz: 1'b0});
        sb.push_back('{q: 8'h03, r: 8'h00, of: 1'b0, dz: 1'b0});
        ndone = 0;
        t_first = 0;
        n = 0;
        while (ndone < 2 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                ndone++;
                if (ndone == 1) t_first = cyc;
                else begin
                    chk("held_spacing", cyc - t_first, 11);
                    start = 1'b0;
                end
                pop_compare("held");
            end
        end
        chk("held_done_count", ndone, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("held_idle", busy, 0);

        // Abort: reset four cycles into CALC after a result with nonzero outputs.
        run_op("pre_abort", 8'h9C, 8'd7, 8'hF2, 8'hFE, 0, 0, 0);
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quot", quot, 8'h00);
        chk("abort_rem", rem, 8'h00);
        chk("abort_of", of, 0);
        chk("abort_dz", dz, 0);
        abort_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) abort_seen = 1'b1;
        end
        chk("abort_no_done", abort_seen, 0);
        last_q = 8'h00;
        last_r = 8'h00;
        run_op("p50_6", 8'd50, 8'd6, 8'h08, 8'h02, 0, 0, 0);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
